mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported memory controller. It shares the controller between the instruction-fetch port and the load/store data port. It serialises their requests and issues exactly one single-cycle start pulse per access. It waits for the controller's one-cycle ready strobe, captures read data, and returns a one-cycle done pulse to the owning requester.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-ported memory controller between the instruction-fetch
// port and the load/store data port. Requests are serialised, and each access
// issues exactly one single-cycle start pulse (m_enable). The arbiter then
// waits for the controller's one-cycle ready strobe, captures read data into
// the owner's rdata register, and returns a one-cycle done pulse to the owner.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties (opposite of grant_d)
//                  undefined -> fixed priority, data port always wins
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   if_req/if_addr               fetch request and address
//   if_rdata/if_done             fetched word (registered), completion pulse
//   d_req/d_we/d_addr/d_wdata    data request, store flag, address, store data
//   d_rdata/d_done               load data (registered), completion pulse
//   m_addr/m_we/m_wdata          registered command to the memory controller
//   m_enable                     one-cycle start pulse to the controller
//   m_rdata/m_ready              controller read data and ready strobe
//   busy                         high whenever the FSM is not in IDLE
//   grant_d                      owner of current/last access (1 = data)
// ---------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [23:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [23:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [23:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wdata,
    output logic        m_enable,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        busy,
    output logic        grant_d
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic any_req;
    logic pick_d;

    assign any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not own the previous access wins; a lone
    // requester always wins.
    assign pick_d = d_req & (~if_req | ~grant_d);
`else
    // Data port has absolute priority; fetch may starve.
    assign pick_d = d_req;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode. Outputs are pure functions of the state
    // (plus owner), so an asynchronous reset clears them immediately.
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        m_enable   = 1'b0;
        busy       = 1'b1;
        if_done    = 1'b0;
        d_done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // m_ready is deliberately ignored here.
                m_enable   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (m_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if_done    = ~grant_d;
                d_done     = grant_d;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Command registers: loaded only on a grant in IDLE, so they stay stable
    // through ISSUE, WAIT and DONE whatever the requesters do meanwhile.
    // grant_d resets to 1 so the first round-robin tie goes to fetch.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr  <= 24'h0;
            m_we    <= 1'b0;
            m_wdata <= 32'h0;
            grant_d <= 1'b1;
        end else if (state == IDLE && any_req) begin
            grant_d <= pick_d;
            if (pick_d) begin
                m_addr  <= d_addr;
                m_we    <= d_we;
                m_wdata <= d_wdata;
            end else begin
                m_addr  <= if_addr;
                m_we    <= 1'b0;
                m_wdata <= 32'h0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read-data capture: m_rdata is only valid alongside m_ready in WAIT.
    // Stores complete without touching either rdata register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= 32'h0;
            d_rdata  <= 32'h0;
        end else if (state == WAIT && m_ready) begin
            if (grant_d) begin
                if (!m_we) begin
                    d_rdata <= m_rdata;
                end
            end else begin
                if_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small memory-controller model answers
// each start pulse with a one-cycle ready strobe a fixed time later and can
// optionally emit a stray ready during the start cycle. Set MEM_ARB_RR_EN at
// compile time to exercise the round-robin build.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [23:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [23:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic        m_enable;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        busy;
    logic        grant_d;

    int n_checks = 0;
    int n_fail   = 0;

    // Written only by the memory model process.
    int en_count       = 0;
    int en_consec_err  = 0;
    int both_done_err  = 0;

    // Written only by the stimulus process.
    logic stray = 1'b0;

    mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .m_addr   (m_addr),
        .m_we     (m_we),
        .m_wdata  (m_wdata),
        .m_enable (m_enable),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .busy     (busy),
        .grant_d  (grant_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory controller model, driven on the falling edge. A start seen in
    // cycle 0-1 produces m_ready sampled by the arbiter at edge 5.
    initial begin : mem_model
        logic [31:0] mem [0:63];
        logic [23:0] lat_addr;
        logic        lat_we;
        logic        prev_en;
        int          cnt;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]   = 32'h0080_016f;
        mem[1]   = 32'h00a0_0093;
        mem[2]   = 32'hcafe_0002;
        mem[4]   = 32'ha5a5_5a5a;
        m_ready  = 1'b0;
        m_rdata  = 32'hdead_beef;
        lat_addr = 24'h0;
        lat_we   = 1'b0;
        prev_en  = 1'b0;
        cnt      = 0;
        forever begin
            @(negedge clk);
            m_ready = 1'b0;
            m_rdata = 32'hdead_beef;
            if (m_enable && prev_en) en_consec_err++;
            if (if_done && d_done) both_done_err++;
            prev_en = m_enable;
            if (m_enable) en_count++;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        m_ready = 1'b1;
                        m_rdata = lat_we ? 32'hdead_beef : mem[lat_addr[7:2]];
                    end
                end
                if (m_enable) begin
                    lat_addr = m_addr;
                    lat_we   = m_we;
                    if (m_we) mem[m_addr[7:2]] = m_wdata;
                    cnt = 4;
                    if (stray) begin
                        m_ready = 1'b1;
                        m_rdata = 32'h1111_1111;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Ticks until a done pulse is visible (bounded), reporting the owner and
    // the number of edges taken.
    task automatic wait_done(input string tag, output logic was_d, output int cycles);
        logic seen;
        seen   = 1'b0;
        was_d  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (if_done || d_done) begin
                seen  = 1'b1;
                was_d = d_done;
                break;
            end
        end
        if (!seen) check({tag, "_done_seen"}, 32'(if_done | d_done), 32'd1);
    endtask

    initial begin : stimulus
        logic wd;
        logic exp_d;
        int   cyc;
        int   en_before;

        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = 24'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 24'h0;
        d_wdata = 32'h0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_m_enable", 32'(m_enable), 32'd0);
        check("rst_grant_d",  32'(grant_d),  32'd1);
        check("rst_m_addr",   32'(m_addr),   32'd0);
        check("rst_m_we",     32'(m_we),     32'd0);
        check("rst_if_rdata", if_rdata,      32'd0);
        check("rst_d_rdata",  d_rdata,       32'd0);
        check("rst_dones",    32'({if_done, d_done}), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- Single fetch ----------------
        en_before = en_count;
        if_addr = 24'h000000;
        if_req  = 1'b1;
        wait_done("fetch1", wd, cyc);
        check("fetch1_owner",   32'(wd),      32'd0);
        check("fetch1_latency", 32'(cyc),     32'd6);
        check("fetch1_rdata",   if_rdata,     32'h0080_016f);
        check("fetch1_m_we",    32'(m_we),    32'd0);
        check("fetch1_grant",   32'(grant_d), 32'd0);
        if_req = 1'b0;
        tick();
        check("fetch1_done_width", 32'({if_done, d_done}), 32'd0);
        check("fetch1_idle",       32'(busy),              32'd0);
        check("fetch1_en_pulses",  32'(en_count - en_before), 32'd1);

        // ---------------- Store then load ----------------
        d_we    = 1'b1;
        d_addr  = 24'h00000c;
        d_wdata = 32'h0102_0304;
        d_req   = 1'b1;
        tick();
        check("store_issue_en", 32'(m_enable), 32'd1);
        check("store_issue_we", 32'(m_we),     32'd1);
        tick();
        check("store_wait_en",    32'(m_enable), 32'd0);
        check("store_wait_we",    32'(m_we),     32'd1);
        check("store_wait_wdata", m_wdata,       32'h0102_0304);
        check("store_wait_addr",  32'(m_addr),   32'h0000_000c);
        tick();
        check("store_wait2_wdata", m_wdata,    32'h0102_0304);
        check("store_wait2_we",    32'(m_we),  32'd1);
        wait_done("store", wd, cyc);
        check("store_owner",   32'(wd),  32'd1);
        check("store_latency", 32'(cyc), 32'd3);
        check("store_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        tick();
        d_we  = 1'b0;
        d_req = 1'b1;
        wait_done("load", wd, cyc);
        check("load_owner",    32'(wd),  32'd1);
        check("load_latency",  32'(cyc), 32'd6);
        check("load_d_rdata",  d_rdata,  32'h0102_0304);
        check("load_if_rdata", if_rdata, 32'h0080_016f);
        d_req = 1'b0;
        tick();

        // ---------------- Simultaneous requests, 6 accesses ----------------
        if_addr = 24'h000004;
        d_addr  = 24'h000008;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_d = (i % 2) == 1;
`else
            exp_d = 1'b1;
`endif
            wait_done("tie", wd, cyc);
            check("tie_grant_order", 32'(wd), 32'(exp_d));
            check("tie_latency", 32'(cyc), (i == 0) ? 32'd6 : 32'd7);
            if (exp_d) check("tie_d_rdata",  d_rdata,  32'hcafe_0002);
            else       check("tie_if_rdata", if_rdata, 32'h00a0_0093);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();

        // ---------------- Stray ready during ISSUE ----------------
        stray   = 1'b1;
        if_addr = 24'h000010;
        if_req  = 1'b1;
        wait_done("stray", wd, cyc);
        check("stray_owner",   32'(wd),  32'd0);
        check("stray_latency", 32'(cyc), 32'd6);
        check("stray_rdata",   if_rdata, 32'ha5a5_5a5a);
        stray  = 1'b0;
        if_req = 1'b0;
        tick();

        // ---------------- Reset mid-access ----------------
        if_addr = 24'h000000;
        if_req  = 1'b1;
        tick();
        tick();
        tick();
        check("abort_in_wait", 32'({busy, m_enable}), 32'b10);
        rst_n = 1'b0;
        #1;
        check("abort_busy",     32'(busy),              32'd0);
        check("abort_m_enable", 32'(m_enable),          32'd0);
        check("abort_dones",    32'({if_done, d_done}), 32'd0);
        check("abort_grant_d",  32'(grant_d),           32'd1);
        check("abort_m_addr",   32'(m_addr),            32'd0);
        check("abort_rdata",    if_rdata,               32'd0);
        tick();
        tick();
        check("abort_hold_dones", 32'({if_done, d_done, busy}), 32'd0);
        rst_n = 1'b1;
        wait_done("post_rst", wd, cyc);
        check("post_rst_owner",   32'(wd),  32'd0);
        check("post_rst_latency", 32'(cyc), 32'd6);
        check("post_rst_rdata",   if_rdata, 32'h0080_016f);
        if_req = 1'b0;
        tick();

        // ---------------- Back-to-back fetches ----------------
        if_addr = 24'h000000;
        if_req  = 1'b1;
        wait_done("b2b1", wd, cyc);
        check("b2b1_rdata", if_rdata, 32'h0080_016f);
        if_addr = 24'h000004;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cyc++;
            if (m_enable) break;
        end
        check("b2b_gap",    32'(cyc),    32'd2);
        check("b2b_m_addr", 32'(m_addr), 32'h0000_0004);
        wait_done("b2b2", wd, cyc);
        check("b2b2_owner",   32'(wd),  32'd0);
        check("b2b2_latency", 32'(cyc), 32'd5);
        check("b2b2_rdata",   if_rdata, 32'h00a0_0093);
        if_req = 1'b0;
        tick();
        tick();

        // ---------------- Global properties ----------------
        check("en_never_consecutive", 32'(en_consec_err), 32'd0);
        check("dones_exclusive",      32'(both_done_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
